// File: rtl/mem_arbiter.sv
// mem_arbiter: sequential arbiter between instruction fetch (IF) and load/store (MEM) on a single
// byte-wide RAM port. Word/half/byte accesses are split into byte transfers (little-endian), read
// bytes are assembled into a 32-bit word, and each requester gets a one-cycle done pulse.
// Optional feature macro: MEMARB_IO_STALL_EN adds io_buffer_full, which holds off MEM stores into
// the IO region (mem_addr >= IO_BASE) while the IO buffer is full.
module mem_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h0003_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
`ifdef MEMARB_IO_STALL_EN
  ,
  input  logic              io_buffer_full
`endif
);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e            state_q, state_d;
  logic [2:0]        stage_q, stage_d;   // 0..N
  logic [2:0]        len_q, len_d;       // byte count N: 1, 2 or 4
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              mem_hold;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] addr_cur;
  logic [7:0]        wr_byte;

  // Reserved length code 2'b10 is served as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    unique case (len)
      2'b00:   len_to_n = 3'd1;
      2'b01:   len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

`ifdef MEMARB_IO_STALL_EN
  // An IO store waits while the IO buffer is full; IF may be granted in the meantime.
  assign mem_hold = mem_wr & (mem_addr >= IO_BASE) & io_buffer_full;
`else
  assign mem_hold = 1'b0;
`endif

  // Byte slot captured at this edge is (stage-1); stage 4 wraps to slot 3 in two bits.
  assign byte_idx = stage_q[1:0] - 2'd1;
  assign addr_cur = base_q + ADDR_W'(stage_q);
  assign wr_byte  = wdata_q[{stage_q[1:0], 3'b000} +: 8];

  // Next-state: arbitration, stage sequencing, read-byte capture and done pulses.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    // rdy low freezes every register, including a pending done.
    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          // The cycle after any done is dead: no accept while a done is high.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req && !mem_hold) begin
              state_d = mem_wr ? StMemWr : StMemRd;
              stage_d = 3'd0;
              len_d   = len_to_n(mem_len);
              base_d  = mem_addr;
              wdata_d = mem_wdata;
              buf_d   = 32'h0;
            end else if (if_req) begin
              state_d = StIfRd;
              stage_d = 3'd0;
              len_d   = 3'd4;
              base_d  = if_addr;
              buf_d   = 32'h0;
            end
          end
        end
        StIfRd, StMemRd: begin
          // ram_din lags the address by one cycle, so stage k holds byte k-1.
          if (stage_q != 3'd0) begin
            buf_d[{byte_idx, 3'b000} +: 8] = ram_din;
          end
          if (stage_q == len_q) begin
            state_d = StIdle;
            stage_d = 3'd0;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end
        StMemWr: begin
          if (stage_q == len_q - 3'd1) begin
            state_d    = StIdle;
            stage_d    = 3'd0;
            mem_done_d = 1'b1;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end
        default: begin
          state_d = StIdle;
          stage_d = 3'd0;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      stage_q     <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM port drive; rst blanks it so a store cut off by reset writes nothing more.
  always_comb begin
    ram_rw   = 1'b0;
    ram_addr = if_addr;
    ram_dout = 8'h00;
    unique case (state_q)
      StIfRd, StMemRd: begin
        // While frozen, re-present the previous address so ram_din keeps the byte due next.
        if (rdy || stage_q == 3'd0) begin
          ram_addr = addr_cur;
        end else begin
          ram_addr = addr_cur - ADDR_W'(1);
        end
      end
      StMemWr: begin
        ram_rw   = rdy;
        ram_addr = addr_cur;
        ram_dout = wr_byte;
      end
      default: ;
    endcase
    if (rst) begin
      ram_rw   = 1'b0;
      ram_addr = '0;
      ram_dout = 8'h00;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds checked against
// a transaction-level model (byte-array RAM, fixed per-access latencies counted in active edges).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
`ifdef MEMARB_IO_STALL_EN
  logic        io_full;
`endif

  int checks = 0;
  int errors = 0;
  int act = 0;   // rising edges with rdy=1
  int cyc = 0;   // all rising edges

  // Physical RAM seen by the DUT, and the reference copy the model updates.
  logic [7:0]  ram_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [39:0] wlog [$];
  logic        mem_init = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  mem_arbiter #(
    .ADDR_W (32),
    .IO_BASE(32'h0003_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_data  (if_data),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_len  (mem_len),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
`ifdef MEMARB_IO_STALL_EN
    ,
    .io_buffer_full(io_full)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bg(input int i);
    bg = 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  // Byte RAM: data for the address of this cycle appears on ram_din next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdy) act <= act + 1;
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= bg(i);
    end else if (pre_we) begin
      ram_mem[pre_addr] <= pre_data;
    end
    if (ram_rw) begin
      ram_mem[ram_addr[15:0]] <= ram_dout;
      wlog.push_back({ram_addr, ram_dout});
    end
    ram_din <= ram_mem[ram_addr[15:0]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a[15:0];
    pre_data = b;
    ref_mem[a[15:0]] = b;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One round: optional MEM and IF request raised together; MEM is served first, IF two
  // active edges after MEM done. stall_mode 0: rdy=1, 1: random rdy, 2: 3-cycle freeze at stage 2.
  task automatic run_round(input bit do_if, input bit do_mem, input bit wr, input logic [1:0] len,
                           input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                           input int stall_mode);
    int n_m, lat_m, start, cyc0, wbase, exp_m, i_acc, exp_i, nstall, nwr;
    logic [31:0] exp_md, exp_id, a;
    bit m_seen, i_seen;
    n_m    = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    lat_m  = wr ? n_m : n_m + 1;
    exp_md = 32'h0;
    exp_id = 32'h0;
    if (do_mem) begin
      for (int i = 0; i < n_m; i++) begin
        a = ma + 32'(i);
        if (wr) ref_mem[a[15:0]] = wd[8*i +: 8];
        else exp_md[8*i +: 8] = ref_mem[a[15:0]];
      end
    end
    if (do_if) begin
      for (int i = 0; i < 4; i++) begin
        a = ia + 32'(i);
        exp_id[8*i +: 8] = ref_mem[a[15:0]];
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    if_req = do_if;   if_addr = ia;
    mem_req = do_mem; mem_wr = wr; mem_len = len; mem_addr = ma; mem_wdata = wd;
    start  = act;
    cyc0   = cyc;
    wbase  = wlog.size();
    exp_m  = start + 1 + lat_m;
    i_acc  = do_mem ? exp_m + 2 : start + 1;
    exp_i  = i_acc + 5;
    m_seen = !do_mem;
    i_seen = !do_if;
    nstall = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (mem_done && !m_seen) begin
        m_seen = 1'b1;
        mem_req = 1'b0;
        check_eq("mem_done_edge", 64'(act), 64'(exp_m));
        if (!wr) check_eq("mem_rdata", 64'(mem_rdata), 64'(exp_md));
      end
      if (if_done && !i_seen) begin
        i_seen = 1'b1;
        if_req = 1'b0;
        check_eq("if_done_edge", 64'(act), 64'(exp_i));
        check_eq("if_data", 64'(if_data), 64'(exp_id));
        if (stall_mode == 2) check_eq("if_done_cycles", 64'(cyc - cyc0), 64'd9);
      end
      if (m_seen && i_seen) break;
      // Requesters may change fields after accept; the DUT must have latched them.
      if (mem_req && act > start) begin
        mem_addr = $urandom; mem_len = 2'($urandom); mem_wdata = $urandom;
      end
      if (if_req && act >= i_acc) if_addr = $urandom;
      if (stall_mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else if (stall_mode == 2 && act == start + 3 && nstall < 3) begin
        rdy = 1'b0;
        nstall++;
      end else begin
        rdy = 1'b1;
      end
      #1;
      if (!rdy) check_eq("ram_rw_frozen", 64'(ram_rw), 64'd0);
      if (stall_mode == 2 && !rdy) check_eq("frozen_addr", 64'(ram_addr), 64'(ia + 32'd1));
    end
    check_eq("done_seen", {62'd0, m_seen, i_seen}, 64'd3);
    if_req = 1'b0;
    mem_req = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check_eq("dones_low", {62'd0, if_done, mem_done}, 64'd0);
    @(negedge clk);
    nwr = (do_mem && wr) ? n_m : 0;
    check_eq("write_count", 64'(wlog.size() - wbase), 64'(nwr));
    if (wlog.size() - wbase == nwr) begin
      for (int i = 0; i < nwr; i++) begin
        check_eq("write_bus", 64'(wlog[wbase + i]), 64'({ma + 32'(i), wd[8*i +: 8]}));
      end
    end
    if (do_mem) begin
      for (int i = 0; i < 4; i++) begin
        a = ma + 32'(i);
        check_eq("ram_content", 64'(ram_mem[a[15:0]]), 64'(ref_mem[a[15:0]]));
      end
    end
  endtask

  initial begin
    int wbase;
    bit di, dm, w;
    logic [1:0]  ln;
    logic [31:0] ia, ma, wd;

    for (int i = 0; i < 65536; i++) ref_mem[i] = bg(i);
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
`ifdef MEMARB_IO_STALL_EN
    io_full = 1'b0;
`endif
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check_eq("rst_if_done", 64'(if_done), 64'd0);
    check_eq("rst_mem_done", 64'(mem_done), 64'd0);
    check_eq("rst_if_data", 64'(if_data), 64'd0);
    check_eq("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check_eq("rst_ram_rw", 64'(ram_rw), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_ram_dout", 64'(ram_dout), 64'd0);
    rst = 1'b0;

    // Instruction fetch 13 05 00 00 at 0x100, then the same with a 3-cycle freeze.
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    run_round(1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 0);
    run_round(1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 2);

    // Simultaneous MEM word load and IF: MEM first.
    preload(32'h200, 8'hAA); preload(32'h201, 8'hBB);
    preload(32'h202, 8'hCC); preload(32'h203, 8'hDD);
    run_round(1'b1, 1'b1, 1'b0, 2'b11, 32'h100, 32'h200, 32'h0, 0);

    // Half store, byte load (zero-extension), reserved length code, address wrap.
    run_round(1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h10, 32'h1234_5678, 0);
    run_round(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h11, 32'h0, 0);
    run_round(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h200, 32'h0, 0);
    preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
    preload(32'h0000_0000, 8'h33); preload(32'h0000_0001, 8'h44);
    run_round(1'b0, 1'b1, 1'b0, 2'b11, 32'h0, 32'hFFFF_FFFE, 32'h0, 0);

    // Reset during stage 1 of a word store: only byte 0 reaches RAM.
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'b11; mem_addr = 32'h40; mem_wdata = 32'hA1B2_C3D4;
    wbase = wlog.size();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_store_done", 64'(mem_done), 64'd0);
    @(negedge clk);
    check_eq("rst_store_done2", 64'(mem_done), 64'd0);
    check_eq("rst_store_writes", 64'(wlog.size() - wbase), 64'd1);
    check_eq("rst_store_b0", 64'(ram_mem[16'h40]), 64'hD4);
    check_eq("rst_store_b1", 64'(ram_mem[16'h41]), 64'(ref_mem[16'h41]));
    ref_mem[16'h40] = 8'hD4;
    run_round(1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0, 0);

`ifdef MEMARB_IO_STALL_EN
    // IO store held off while the IO buffer is full.
    @(negedge clk);
    io_full = 1'b1;
    mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'b11; mem_addr = 32'h0003_0000;
    mem_wdata = 32'h5566_7788;
    wbase = wlog.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("io_hold_rw", 64'(ram_rw), 64'd0);
    end
    io_full = 1'b0;
    for (int i = 0; i < 20 && !mem_done; i++) @(negedge clk);
    check_eq("io_store_done", 64'(mem_done), 64'd1);
    mem_req = 1'b0;
    check_eq("io_store_writes", 64'(wlog.size() - wbase), 64'd4);
    for (int i = 0; i < 4; i++) ref_mem[i] = mem_wdata[8*i +: 8];
    @(negedge clk);
`endif

    // Randomized rounds with random rdy freezes.
    for (int r = 0; r < 40; r++) begin
      dm = ($urandom_range(0, 3) != 0);
      di = !dm || ($urandom_range(0, 1) != 0);
      w  = ($urandom_range(0, 1) != 0);
      ln = 2'($urandom);
      ia = 32'h380 + $urandom_range(0, 120);
      ma = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                        : 32'h380 + $urandom_range(0, 120);
      wd = $urandom;
      run_round(di, dm, w, ln, ia, ma, wd, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
